demux1_8_reg: RTL

//   Registered 1-to-N byte distributor; the write-side counterpart of the 8:1 byte mux.

---
 rtl/demux1_8_reg_pkg.sv | 16 +
 rtl/demux1_8_reg_if.sv | 26 ++
 rtl/demux1_8_reg_chan.sv | 52 +++++
 rtl/demux1_8_reg.sv | 81 ++++++++
 4 files changed

// File: rtl/demux1_8_reg_pkg.sv
// Shared constants and types for the registered 1-to-N byte distributor.
package demux_pkg;

    localparam int WIDTH = 8;
    localparam int N     = 8;
    localparam int LOG2N = 3;

    typedef logic [LOG2N-1:0] ch_idx_t;
    typedef logic [WIDTH-1:0] byte_t;

    // Round-robin successor; N is a power of two so the natural wrap is mod N.
    function automatic ch_idx_t ptr_next(input ch_idx_t p);
        return p + ch_idx_t'(1);
    endfunction

endpackage

// File: rtl/demux1_8_reg_if.sv
// Input stream, per-channel outputs and round-robin pointer of the distributor.
interface demux1_8_reg_if;
    import demux_pkg::*;

    byte_t                din;
    logic                 in_valid;
    logic                 in_ready;
    ch_idx_t              sel;
    logic                 auto_mode;
    logic [N*WIDTH-1:0]   out_data;
    logic [N-1:0]         out_valid;
    logic [N-1:0]         out_ready;
    ch_idx_t              rr_ptr;

    // Producer and consumers of the block.
    modport master (
        output din, in_valid, sel, auto_mode, out_ready,
        input  in_ready, out_data, out_valid, rr_ptr
    );

    // The distributor itself.
    modport slave (
        input  din, in_valid, sel, auto_mode, out_ready,
        output in_ready, out_data, out_valid, rr_ptr
    );
endinterface

// File: rtl/demux1_8_reg_chan.sv
// One-entry holding register for a single output channel.
// A load wins over a drain, so a byte can be replaced in the same cycle the
// consumer takes the previous one (full-rate streaming into a ready channel).
module demux_chan_reg
    import demux_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  byte_t data_in,
    input  logic  ready,
    output logic  valid,
    output byte_t data_out,
    output logic  can_load
);

    logic  valid_d;
    logic  valid_q;
    byte_t data_d;
    byte_t data_q;

    // Next-state: load replaces the entry, otherwise a consumed entry empties.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = data_in;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Entry state, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid    = valid_q;
    assign data_out = data_q;
    // Free now, or freed by the consumer on this same edge.
    assign can_load = !valid_q || ready;

endmodule

// File: rtl/demux1_8_reg.sv
// Registered 1-to-N byte distributor: steers each accepted input byte into the
// holding register of the selected (or round-robin) channel.
module demux1_8_reg
    import demux_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    demux1_8_reg_if.slave  bus
);

    ch_idx_t            ch_s;
    logic               in_ready_s;
    logic               accept_s;
    logic [N-1:0]       load_s;
    logic [N-1:0]       can_load_s;
    logic [N-1:0]       valid_s;
    byte_t              data_s [N];
    logic [N*WIDTH-1:0] out_data_s;
    ch_idx_t            rr_ptr_d;
    ch_idx_t            rr_ptr_q;

    // Target channel and input handshake; mode and select act in the same cycle.
    always_comb begin
        ch_s       = bus.auto_mode ? rr_ptr_q : bus.sel;
        in_ready_s = can_load_s[ch_s];
        accept_s   = bus.in_valid && in_ready_s;
    end

    // One-hot load strobe for the target channel.
    always_comb begin
        load_s = '0;
        for (int k = 0; k < N; k++) begin
            load_s[k] = accept_s && (ch_s == ch_idx_t'(k));
        end
    end

    // Pointer advances only on a round-robin accept; a stalled target blocks.
    always_comb begin
        if (accept_s && bus.auto_mode) begin
            rr_ptr_d = ptr_next(rr_ptr_q);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_chan
        demux_chan_reg u_chan (
            .clk      (clk),
            .rst      (rst),
            .load     (load_s[g]),
            .data_in  (bus.din),
            .ready    (bus.out_ready[g]),
            .valid    (valid_s[g]),
            .data_out (data_s[g]),
            .can_load (can_load_s[g])
        );
    end

    // Flatten channel registers onto the output bus.
    always_comb begin
        out_data_s = '0;
        for (int k = 0; k < N; k++) begin
            out_data_s[k*WIDTH +: WIDTH] = data_s[k];
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = valid_s;
    assign bus.out_data  = out_data_s;
    assign bus.rr_ptr    = rr_ptr_q;

endmodule
